// File: rtl/io_port_pkg.sv
// Shared types and defaults for the CPU parallel I/O port controller.
package io_port_pkg;

   localparam int DATA_W_DEFAULT = 32;

   typedef enum logic {
      IDLE = 1'b0,
      HELD = 1'b1
   } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO with a registered head word and occupancy count.
module sync_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4,
   parameter int AW     = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              pop,
   output logic              full,
   output logic              empty,
   output logic [AW:0]       count,
   output logic [DATA_W-1:0] head
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] ZERO_CNT = {(AW+1){1'b0}};

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       count_q;
   logic [DATA_W-1:0] head_q;

   logic              push_ok;
   logic              pop_ok;
   logic [AW:0]       remaining;
   logic [AW:0]       count_next;
   logic [AW-1:0]     rd_next;
   logic [DATA_W-1:0] head_next;

   assign full    = (count_q == FULL_CNT);
   assign empty   = (count_q == ZERO_CNT);
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign push_ok = push & (~full | pop);
   assign pop_ok  = pop & ~empty;
   assign count   = count_q;
   assign head    = head_q;

   // Next-state for count, read pointer and the registered head word.
   always_comb begin
      remaining  = count_q - (AW+1)'(pop_ok);
      count_next = remaining + (AW+1)'(push_ok);
      rd_next    = pop_ok ? (rd_ptr + AW'(1)) : rd_ptr;
      head_next  = head_q;
      if (push_ok && (remaining == ZERO_CNT)) begin
         head_next = wr_data;
      end else if (count_next != ZERO_CNT) begin
         head_next = mem[rd_next];
      end else begin
         head_next = head_q;
      end
   end

   // Storage array; contents after reset are don't-care.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers, occupancy and head register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= {AW{1'b0}};
         rd_ptr  <= {AW{1'b0}};
         count_q <= ZERO_CNT;
         head_q  <= {DATA_W{1'b0}};
      end else begin
         wr_ptr  <= push_ok ? (wr_ptr + AW'(1)) : wr_ptr;
         rd_ptr  <= rd_next;
         count_q <= count_next;
         head_q  <= head_next;
      end
   end

endmodule

// File: rtl/io_port_ctrl.sv
// Device-side partner of the CPU I/O ports: outbound write FIFO, inbound
// single-word holding register, and sticky overflow/underrun flags.
module io_port_ctrl
   import io_port_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT,
   parameter int DEPTH  = 4,
   parameter int AW     = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              out_wr,
   input  logic [DATA_W-1:0] out_data,
   output logic [DATA_W-1:0] dev_tx_data,
   output logic              dev_tx_valid,
   input  logic              dev_tx_ready,
   input  logic [DATA_W-1:0] dev_rx_data,
   input  logic              dev_rx_valid,
   output logic              dev_rx_ready,
   output logic [DATA_W-1:0] inport_data,
   output logic              in_avail,
   input  logic              in_rd,
   output logic [AW:0]       out_count,
   output logic              ovf_err,
   output logic              unf_err,
   input  logic              clr_err
);

   rx_state_t state;
   logic      fifo_full;
   logic      fifo_empty;
   logic      pop_req;
   logic      ovf_evt;
   logic      unf_evt;

   assign dev_tx_valid = ~fifo_empty;
   assign pop_req      = dev_tx_valid & dev_tx_ready;
   assign ovf_evt      = out_wr & fifo_full & ~pop_req;
   assign unf_evt      = in_rd & ~in_avail;
   assign dev_rx_ready = (state == IDLE);

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (out_wr),
      .wr_data (out_data),
      .pop     (pop_req),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (out_count),
      .head    (dev_tx_data)
   );

   // Inbound capture FSM; inport_data keeps the last word after it is read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         inport_data <= {DATA_W{1'b0}};
         in_avail    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (dev_rx_valid) begin
                  inport_data <= dev_rx_data;
                  in_avail    <= 1'b1;
                  state       <= HELD;
               end
            end
            HELD: begin
               if (in_rd) begin
                  in_avail <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: begin
               in_avail <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

   // Sticky error flags; a new event wins over a same-cycle clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_err <= 1'b0;
         unf_err <= 1'b0;
      end else begin
         if (ovf_evt) begin
            ovf_err <= 1'b1;
         end else if (clr_err) begin
            ovf_err <= 1'b0;
         end
         if (unf_evt) begin
            unf_err <= 1'b1;
         end else if (clr_err) begin
            unf_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Table-driven bench for io_port_ctrl plus a hand-written asynchronous reset sequence.
module tb_io_port_ctrl;

   typedef struct packed {
      logic        wr;
      logic [31:0] wd;
      logic        rdy;
      logic        rxv;
      logic [31:0] rxd;
      logic        rd;
      logic        clr;
      logic        tv;
      logic [31:0] td;
      logic [2:0]  cnt;
      logic        rxr;
      logic [31:0] ind;
      logic        av;
      logic        ovf;
      logic        unf;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        out_wr;
   logic [31:0] out_data;
   logic [31:0] dev_tx_data;
   logic        dev_tx_valid;
   logic        dev_tx_ready;
   logic [31:0] dev_rx_data;
   logic        dev_rx_valid;
   logic        dev_rx_ready;
   logic [31:0] inport_data;
   logic        in_avail;
   logic        in_rd;
   logic [2:0]  out_count;
   logic        ovf_err;
   logic        unf_err;
   logic        clr_err;

   int n_checks;
   int n_fail;
   vec_t vecs [27];

   io_port_ctrl #(.DATA_W(32), .DEPTH(4), .AW(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .out_wr       (out_wr),
      .out_data     (out_data),
      .dev_tx_data  (dev_tx_data),
      .dev_tx_valid (dev_tx_valid),
      .dev_tx_ready (dev_tx_ready),
      .dev_rx_data  (dev_rx_data),
      .dev_rx_valid (dev_rx_valid),
      .dev_rx_ready (dev_rx_ready),
      .inport_data  (inport_data),
      .in_avail     (in_avail),
      .in_rd        (in_rd),
      .out_count    (out_count),
      .ovf_err      (ovf_err),
      .unf_err      (unf_err),
      .clr_err      (clr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(logic wr, logic [31:0] wd, logic rdy, logic rxv, logic [31:0] rxd,
                               logic rd, logic clr, logic tv, logic [31:0] td, logic [2:0] cnt,
                               logic rxr, logic [31:0] ind, logic av, logic ovf, logic unf);
      vec_t r;
      r.wr = wr; r.wd = wd; r.rdy = rdy; r.rxv = rxv; r.rxd = rxd; r.rd = rd; r.clr = clr;
      r.tv = tv; r.td = td; r.cnt = cnt; r.rxr = rxr; r.ind = ind; r.av = av; r.ovf = ovf; r.unf = unf;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic wr, input logic [31:0] wd, input logic rdy, input logic rxv,
                        input logic [31:0] rxd, input logic rd, input logic clr);
      out_wr = wr; out_data = wd; dev_tx_ready = rdy;
      dev_rx_valid = rxv; dev_rx_data = rxd; in_rd = rd; clr_err = clr;
   endtask

   task automatic check_vec(input int idx, input vec_t v);
      string p;
      p = $sformatf("v%0d", idx);
      chk({p, ".tx_valid"}, {31'd0, dev_tx_valid}, {31'd0, v.tv});
      if (v.tv) chk({p, ".tx_data"}, dev_tx_data, v.td);
      chk({p, ".out_count"}, {29'd0, out_count}, {29'd0, v.cnt});
      chk({p, ".rx_ready"}, {31'd0, dev_rx_ready}, {31'd0, v.rxr});
      chk({p, ".inport_data"}, inport_data, v.ind);
      chk({p, ".in_avail"}, {31'd0, in_avail}, {31'd0, v.av});
      chk({p, ".ovf_err"}, {31'd0, ovf_err}, {31'd0, v.ovf});
      chk({p, ".unf_err"}, {31'd0, unf_err}, {31'd0, v.unf});
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      //              wr    wd      rdy   rxv   rxd        rd    clr   | tv  td        cnt   rxr   ind           av    ovf   unf
      // Outbound ordering with the device stalled, then draining
      vecs[0]  = mk(1'b1, 32'h11, 1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 32'h11, 3'd1, 1'b1, 32'h0,     1'b0, 1'b0, 1'b0);
      vecs[1]  = mk(1'b1, 32'h22, 1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 32'h11, 3'd2, 1'b1, 32'h0,     1'b0, 1'b0, 1'b0);
      vecs[2]  = mk(1'b1, 32'h33, 1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 32'h11, 3'd3, 1'b1, 32'h0,     1'b0, 1'b0, 1'b0);
      vecs[3]  = mk(1'b0, 32'h0,  1'b1, 1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 32'h22, 3'd2, 1'b1, 32'h0,     1'b0, 1'b0, 1'b0);
      vecs[4]  = mk(1'b0, 32'h0,  1'b1, 1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 32'h33, 3'd1, 1'b1, 32'h0,     1'b0, 1'b0, 1'b0);
      vecs[5]  = mk(1'b0, 32'h0,  1'b1, 1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 32'h0,  3'd0, 1'b1, 32'h0,     1'b0, 1'b0, 1'b0);
      // Fill to full, overflow with 0xA4, clear the flag
      vecs[6]  = mk(1'b1, 32'hA0, 1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 32'hA0, 3'd1, 1'b1, 32'h0,     1'b0, 1'b0, 1'b0);
      vecs[7]  = mk(1'b1, 32'hA1, 1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 32'hA0, 3'd2, 1'b1, 32'h0,     1'b0, 1'b0, 1'b0);
      vecs[8]  = mk(1'b1, 32'hA2, 1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 32'hA0, 3'd3, 1'b1, 32'h0,     1'b0, 1'b0, 1'b0);
      vecs[9]  = mk(1'b1, 32'hA3, 1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 32'hA0, 3'd4, 1'b1, 32'h0,     1'b0, 1'b0, 1'b0);
      vecs[10] = mk(1'b1, 32'hA4, 1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 32'hA0, 3'd4, 1'b1, 32'h0,     1'b0, 1'b1, 1'b0);
      vecs[11] = mk(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 1'b1, 32'hA0, 3'd4, 1'b1, 32'h0,     1'b0, 1'b0, 1'b0);
      // Full with simultaneous push and pop, then drain A1..A3, BB
      vecs[12] = mk(1'b1, 32'hBB, 1'b1, 1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 32'hA1, 3'd4, 1'b1, 32'h0,     1'b0, 1'b0, 1'b0);
      vecs[13] = mk(1'b0, 32'h0,  1'b1, 1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 32'hA2, 3'd3, 1'b1, 32'h0,     1'b0, 1'b0, 1'b0);
      vecs[14] = mk(1'b0, 32'h0,  1'b1, 1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 32'hA3, 3'd2, 1'b1, 32'h0,     1'b0, 1'b0, 1'b0);
      vecs[15] = mk(1'b0, 32'h0,  1'b1, 1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 32'hBB, 3'd1, 1'b1, 32'h0,     1'b0, 1'b0, 1'b0);
      vecs[16] = mk(1'b0, 32'h0,  1'b1, 1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 32'h0,  3'd0, 1'b1, 32'h0,     1'b0, 1'b0, 1'b0);
      // Empty with push and ready: push taken, nothing popped
      vecs[17] = mk(1'b1, 32'hC1, 1'b1, 1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 32'hC1, 3'd1, 1'b1, 32'h0,     1'b0, 1'b0, 1'b0);
      vecs[18] = mk(1'b0, 32'h0,  1'b1, 1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 32'h0,  3'd0, 1'b1, 32'h0,     1'b0, 1'b0, 1'b0);
      // Inbound handshake, blocked second word, read, recapture
      vecs[19] = mk(1'b0, 32'h0,  1'b0, 1'b1, 32'hCAFE,  1'b0, 1'b0, 1'b0, 32'h0,  3'd0, 1'b0, 32'hCAFE,  1'b1, 1'b0, 1'b0);
      vecs[20] = mk(1'b0, 32'h0,  1'b0, 1'b1, 32'hBEEF,  1'b0, 1'b0, 1'b0, 32'h0,  3'd0, 1'b0, 32'hCAFE,  1'b1, 1'b0, 1'b0);
      vecs[21] = mk(1'b0, 32'h0,  1'b0, 1'b1, 32'hBEEF,  1'b1, 1'b0, 1'b0, 32'h0,  3'd0, 1'b1, 32'hCAFE,  1'b0, 1'b0, 1'b0);
      vecs[22] = mk(1'b0, 32'h0,  1'b0, 1'b1, 32'hBEEF,  1'b0, 1'b0, 1'b0, 32'h0,  3'd0, 1'b0, 32'hBEEF,  1'b1, 1'b0, 1'b0);
      vecs[23] = mk(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,     1'b1, 1'b0, 1'b0, 32'h0,  3'd0, 1'b1, 32'hBEEF,  1'b0, 1'b0, 1'b0);
      // Underrun, clear racing a new underrun, then a plain clear
      vecs[24] = mk(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,     1'b1, 1'b0, 1'b0, 32'h0,  3'd0, 1'b1, 32'hBEEF,  1'b0, 1'b0, 1'b1);
      vecs[25] = mk(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 1'b0, 32'h0,  3'd0, 1'b1, 32'hBEEF,  1'b0, 1'b0, 1'b1);
      vecs[26] = mk(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 1'b0, 32'h0,  3'd0, 1'b1, 32'hBEEF,  1'b0, 1'b0, 1'b0);

      rst = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset.tx_valid", {31'd0, dev_tx_valid}, 32'd0);
      chk("reset.tx_data", dev_tx_data, 32'd0);
      chk("reset.out_count", {29'd0, out_count}, 32'd0);
      chk("reset.rx_ready", {31'd0, dev_rx_ready}, 32'd1);
      chk("reset.inport_data", inport_data, 32'd0);
      chk("reset.in_avail", {31'd0, in_avail}, 32'd0);
      chk("reset.ovf_err", {31'd0, ovf_err}, 32'd0);
      chk("reset.unf_err", {31'd0, unf_err}, 32'd0);

      for (int i = 0; i < 27; i++) begin
         drive(vecs[i].wr, vecs[i].wd, vecs[i].rdy, vecs[i].rxv, vecs[i].rxd, vecs[i].rd, vecs[i].clr);
         @(posedge clk);
         #1;
         check_vec(i, vecs[i]);
      end

      // Asynchronous reset with two words queued and an inbound word held
      drive(1'b1, 32'hD1, 1'b0, 1'b1, 32'h1234, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      drive(1'b1, 32'hD2, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("pre_rst.out_count", {29'd0, out_count}, 32'd2);
      chk("pre_rst.in_avail", {31'd0, in_avail}, 32'd1);
      chk("pre_rst.inport_data", inport_data, 32'h1234);
      rst = 1'b1;
      #2;
      chk("async_rst.tx_valid", {31'd0, dev_tx_valid}, 32'd0);
      chk("async_rst.tx_data", dev_tx_data, 32'd0);
      chk("async_rst.out_count", {29'd0, out_count}, 32'd0);
      chk("async_rst.in_avail", {31'd0, in_avail}, 32'd0);
      chk("async_rst.rx_ready", {31'd0, dev_rx_ready}, 32'd1);
      chk("async_rst.inport_data", inport_data, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(1'b1, 32'hE5, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("post_rst.tx_valid", {31'd0, dev_tx_valid}, 32'd1);
      chk("post_rst.tx_data", dev_tx_data, 32'hE5);
      chk("post_rst.out_count", {29'd0, out_count}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
